// File: rtl/word_byte_sender.sv
// Drains WORDS_PER_BLOCK 32-bit words from the send FIFO and hands them to a
// UART transmitter one byte at a time, with a one-cycle done pulse per block.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | waiting for In_enable
// FETCH   | waiting for a non-empty FIFO, then strobe rd_en once
// LATCH   | rd_en cycle; FIFO data appears on the following cycle
// SEND    | wait for TX idle, then present byte and pulse tx_start
// ARM     | skip the cycle before TX raises busy
// WAIT_TX | wait for TX to finish the byte
// NEXT    | advance byte / word counters
// DONE    | pulse Out_done, return to IDLE
module word_byte_sender #(
    parameter int TCQ             = 1,
    parameter int WORDS_PER_BLOCK = 4,
    parameter bit MSB_FIRST       = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        In_enable,
    output logic        Out_done,
    input  logic        In_snd_empty,
    input  logic [31:0] In_snd_dout,
    output logic        Out_snd_rd_en,
    output logic [7:0]  Out_tx_data,
    output logic        Out_tx_start,
    input  logic        In_tx_busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LATCH   = 3'd2,
        SEND    = 3'd3,
        ARM     = 3'd4,
        WAIT_TX = 3'd5,
        NEXT    = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [7:0] WPB = 8'(WORDS_PER_BLOCK);

    // TCQ is the simulation register-update delay;
    // the registers here update with zero delay.
    if (TCQ < 0) begin : g_tcq_negative
    end

    state_t      state;
    logic [31:0] word_reg;
    logic [7:0]  word_cnt;
    logic [1:0]  byte_cnt;

    logic [31:0] cur_word;
    logic [1:0]  lane;
    logic [7:0]  sel_byte;

    // The FIFO presents the word in the first SEND cycle, so byte 0 comes
    // straight from In_snd_dout and the word register is loaded as it goes out.
    assign cur_word = (byte_cnt == 2'd0) ? In_snd_dout : word_reg;
    assign lane     = MSB_FIRST ? (2'd3 - byte_cnt) : byte_cnt;

    always_comb begin
        sel_byte = 8'h00;
        case (lane)
            2'd0: sel_byte = cur_word[7:0];
            2'd1: sel_byte = cur_word[15:8];
            2'd2: sel_byte = cur_word[23:16];
            2'd3: sel_byte = cur_word[31:24];
            default: sel_byte = 8'h00;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= IDLE;
            Out_done      <= 1'b0;
            Out_snd_rd_en <= 1'b0;
            Out_tx_start  <= 1'b0;
            Out_tx_data   <= 8'h00;
            word_reg      <= 32'h0;
            word_cnt      <= 8'h00;
            byte_cnt      <= 2'd0;
        end else begin
            Out_done      <= 1'b0;
            Out_snd_rd_en <= 1'b0;
            Out_tx_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (In_enable) begin
                        word_cnt <= 8'h00;
                        byte_cnt <= 2'd0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (!In_snd_empty) begin
                        Out_snd_rd_en <= 1'b1;
                        state         <= LATCH;
                    end
                end
                LATCH: begin
                    state <= SEND;
                end
                SEND: begin
                    if (!In_tx_busy) begin
                        Out_tx_data  <= sel_byte;
                        Out_tx_start <= 1'b1;
                        if (byte_cnt == 2'd0) begin
                            word_reg <= In_snd_dout;
                        end
                        state <= ARM;
                    end
                end
                ARM: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (!In_tx_busy) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (byte_cnt != 2'd3) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        state    <= SEND;
                    end else begin
                        byte_cnt <= 2'd0;
                        word_cnt <= word_cnt + 8'd1;
                        state    <= ((word_cnt + 8'd1) == WPB) ? DONE : FETCH;
                    end
                end
                DONE: begin
                    Out_done <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
